// File: rtl/stopwatch_core.sv
// Millisecond stopwatch: BCD mm:ss.fff live count with run/pause, saturation and lap freeze.
//
// state  | meaning
// IDLE   | cleared, waiting for start
// RUN    | counting one ms per tick_src rising edge
// PAUSED | count held, start resumes
// FULL   | count saturated at MIN_LIMIT:59.999, only clear leaves
module stopwatch_core #(
  parameter int MIN_LIMIT = 59
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        tick_src,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [27:0] digits,
  output logic        running,
  output logic        lap_active,
  output logic        full
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, FULL} state_t;

  localparam logic [3:0]  MIN_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0]  MIN_ONES = 4'(MIN_LIMIT % 10);
  localparam logic [27:0] CNT_MAX  = {MIN_TENS, MIN_ONES, 4'd5, 4'd9, 4'd9, 4'd9, 4'd9};

  state_t      state_q, state_d;
  logic        tick_q, tick, at_max, count_en;
  logic [27:0] cnt_q, cnt_d, lap_q, lap_d;
  logic        lap_active_d, running_d, full_d;

  // Ripple a +1 ms through the seven digits; sec tens wraps at 5, all others at 9.
  function automatic logic [27:0] bcd_inc(input logic [27:0] v);
    logic [27:0] r;
    logic        carry;
    logic [3:0]  lim;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lim = (i == 4) ? 4'd5 : 4'd9;
      if (carry) begin
        if (r[4*i +: 4] == lim) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick     = tick_src & ~tick_q;
  assign at_max   = (cnt_q == CNT_MAX);
  assign count_en = (state_q == RUN) && tick && !at_max;

  always_comb begin
    cnt_d = cnt_q;
    if (btn_clear)     cnt_d = '0;
    else if (count_en) cnt_d = bcd_inc(cnt_q);
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      cnt_q      <= '0;
      lap_q      <= '0;
      lap_active <= 1'b0;
      running    <= 1'b0;
      full       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_src;
      cnt_q      <= cnt_d;
      lap_q      <= lap_d;
      lap_active <= lap_active_d;
      running    <= running_d;
      full       <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (btn_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (btn_start_stop) state_d = RUN;
        RUN: begin
          if (tick && at_max)      state_d = FULL;
          else if (btn_start_stop) state_d = PAUSED;
        end
        PAUSED:  if (btn_start_stop) state_d = RUN;
        FULL:    state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lap snapshot takes cnt_d so a same-cycle tick is part of the frozen value.
  always_comb begin
    lap_d        = lap_q;
    lap_active_d = lap_active;
    running_d    = (state_d == RUN);
    full_d       = (state_d == FULL);
    if (btn_clear) begin
      lap_active_d = 1'b0;
    end else if (btn_lap) begin
      if (lap_active && (state_q == RUN || state_q == PAUSED)) begin
        lap_active_d = 1'b0;
      end else if (!lap_active && state_q == RUN) begin
        lap_d        = cnt_d;
        lap_active_d = 1'b1;
      end
    end
  end

  assign digits = lap_active ? lap_q : cnt_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: integer-millisecond reference model, per-cycle compare.
module tb_stopwatch_core;

  localparam int LIMIT  = 1;
  localparam int MAX_MS = LIMIT * 60000 + 59999;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_FULL = 3;

  logic        clk_100mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_src = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic [27:0] digits;
  logic        running, lap_active, full;

  stopwatch_core #(.MIN_LIMIT(LIMIT)) dut (
    .clk_100mhz    (clk_100mhz),
    .rst_n         (rst_n),
    .tick_src      (tick_src),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .btn_lap       (btn_lap),
    .digits        (digits),
    .running       (running),
    .lap_active    (lap_active),
    .full          (full)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int checks = 0;
  int errors = 0;
  logic [30:0] sb_q[$];

  // Reference model, in plain milliseconds.
  int   m_ms = 0, m_lap_ms = 0, m_st = S_IDLE;
  bit   m_lap_on = 0, m_prev = 0;
  logic src_lvl = 1'b0;
  logic rst_drive = 1'b0;
  bit   pre_req = 0, forced = 0;
  int   pre_val = 0;
  logic [27:0] pre_bcd = '0;

  function automatic logic [27:0] to_bcd(input int ms);
    int m, s, f;
    m = ms / 60000;
    s = (ms / 1000) % 60;
    f = ms % 1000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(f / 100), 4'((f / 10) % 10), 4'(f % 10)};
  endfunction

  task automatic model_reset();
    m_ms = 0; m_lap_ms = 0; m_st = S_IDLE; m_lap_on = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic rst, input logic s, input logic ss,
                            input logic clr, input logic lp);
    bit tk;
    int st0;
    tk     = s && !m_prev;
    m_prev = s;
    if (!rst) begin
      model_reset();
    end else if (clr) begin
      m_ms = 0; m_lap_on = 0; m_st = S_IDLE;
    end else begin
      st0 = m_st;
      case (st0)
        S_IDLE:   if (ss) m_st = S_RUN;
        S_RUN: begin
          if (tk) begin
            if (m_ms == MAX_MS) m_st = S_FULL;
            else m_ms++;
          end
          if (m_st == S_RUN && ss) m_st = S_PAUSED;
        end
        S_PAUSED: if (ss) m_st = S_RUN;
        default: ;
      endcase
      if (lp) begin
        if (m_lap_on && (st0 == S_RUN || st0 == S_PAUSED)) m_lap_on = 0;
        else if (!m_lap_on && st0 == S_RUN) begin
          m_lap_on = 1; m_lap_ms = m_ms;
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic ss, input logic clr, input logic lp);
    logic [27:0] ed;
    @(negedge clk_100mhz);
    if (forced) begin
      release dut.cnt_q;
      forced = 0;
    end
    rst_n = rst_drive;
    tick_src = s; btn_start_stop = ss; btn_clear = clr; btn_lap = lp;
    src_lvl = s;
    model_step(rst_drive, s, ss, clr, lp);
    if (pre_req) begin
      pre_bcd = to_bcd(pre_val);
      force dut.cnt_q = pre_bcd;
      forced  = 1;
      pre_req = 0;
      m_ms    = pre_val;
    end
    ed = m_lap_on ? to_bcd(m_lap_ms) : to_bcd(m_ms);
    sb_q.push_back({ed, m_st == S_RUN, m_lap_on, m_st == S_FULL});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(src_lvl, 0, 0, 0);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
    end
  endtask

  task automatic press(input logic ss, input logic clr, input logic lp);
    step(src_lvl, ss, clr, lp);
  endtask

  // Live-count preload; the step carries no tick and no buttons.
  task automatic preload(input int ms);
    pre_val = ms;
    pre_req = 1;
    step(src_lvl, 0, 0, 0);
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    logic [30:0] exp, act;
    forever begin
      @(posedge clk_100mhz);
      #1;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        act = {digits, running, lap_active, full};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL out t=%0t: got digits=%h run=%b lap=%b full=%b expected digits=%h run=%b lap=%b full=%b",
                   $time, act[30:3], act[2], act[1], act[0], exp[30:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  initial begin : stim
    int phase;
    logic ss, lp, clr;
    rst_drive = 1'b0;
    idle(3);
    rst_drive = 1'b1;
    idle(2);

    press(1, 0, 0);
    edges(1234);
    idle(2);
    press(0, 1, 0);

    press(1, 0, 0);
    edges(2500);
    press(0, 0, 1);
    edges(300);
    press(0, 0, 1);
    idle(2);
    press(0, 1, 0);

    press(1, 0, 0);
    edges(10);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 0, 0, 0);
    edges(5);
    press(0, 1, 0);

    press(1, 0, 0);
    preload(59999);
    edges(1);
    idle(1);
    press(0, 1, 0);

    press(1, 0, 0);
    preload(MAX_MS - 1);
    edges(2);
    press(1, 0, 0);
    edges(2);
    press(0, 0, 1);
    press(0, 1, 0);
    edges(2);

    // Tick on the clear cycle must lose to clear.
    press(1, 0, 0);
    edges(3);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 1, 0);

    // Asynchronous reset mid-run, released with tick_src held high.
    press(1, 0, 0);
    edges(50);
    @(posedge clk_100mhz);
    #2;
    rst_n = 1'b0;
    rst_drive = 1'b0;
    model_reset();
    #1;
    check_now("async_rst_digits", 32'(digits), 32'h0);
    check_now("async_rst_running", 32'(running), 32'h0);
    check_now("async_rst_lap", 32'(lap_active), 32'h0);
    check_now("async_rst_full", 32'(full), 32'h0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    rst_drive = 1'b1;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    press(1, 0, 0);
    idle(3);
    edges(3);
    press(0, 1, 0);

    phase = 2;
    for (int i = 0; i < 5000; i++) begin
      if (phase == 0) begin
        src_lvl = ~src_lvl;
        phase   = $urandom_range(2, 6);
      end
      phase--;
      ss  = ($urandom_range(0, 24) == 0);
      lp  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 299) == 0) preload($urandom_range(MAX_MS - 60, MAX_MS));
      else step(src_lvl, ss, clr, lp);
    end

    idle(2);
    @(posedge clk_100mhz);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
